// File: rtl/i2c_xfer_seq.sv
// i2c_xfer_seq: runs complete register-oriented I2C transfers on top of the
// byte-level master controller. Write: START+addr, reg, N data, STOP.
// Read: START+addr, reg, repeated START+addr|1, N data, STOP.
module i2c_xfer_seq #(
  parameter  int MAX_LEN = 16,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          hclk,
  input  logic          hrst,
  // host request
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [6:0]    req_dev,
  input  logic [7:0]    req_reg,
  input  logic          req_rd,
  input  logic [LW-1:0] req_len,
  // write data stream
  input  logic          tx_valid,
  output logic          tx_ready,
  input  logic [7:0]    tx_data,
  // read data stream
  output logic          rx_valid,
  output logic [7:0]    rx_data,
  // completion
  output logic          done,
  output logic [1:0]    status,
  output logic          busy,
  // byte controller
  output logic          bc_start,
  output logic          bc_stop,
  output logic          bc_read,
  output logic          bc_write,
  output logic          bc_ack_in,
  output logic [7:0]    bc_din,
  input  logic          bc_cmd_ack,
  input  logic          bc_ack_out,
  input  logic [7:0]    bc_dout,
  input  logic          bc_al
);

  typedef enum logic [3:0] {
    IDLE, ADDR_W, REG, TX_FETCH, WDATA, RSTART, RDATA, STOP, FIN
  } state_t;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       read;
    logic       write;
    logic       ack_in;
    logic [7:0] din;
  } cmd_t;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_NACK = 2'b01;
  localparam logic [1:0] ST_AL   = 2'b10;

  state_t        state;
  cmd_t          cmd_q;     // registered command presented to the byte ctrl
  cmd_t          cmd_want;  // command the current state wants to issue
  logic          is_cmd;    // current state talks to the byte ctrl
  logic          cmd_live;  // a command is outstanding, waiting for ack/al
  logic [6:0]    dev_q;
  logic [7:0]    reg_q;
  logic          rd_q;
  logic [LW-1:0] cnt;       // data bytes still to move
  logic [7:0]    wbyte;     // write byte captured from the tx stream
  logic [LW-1:0] len_clamped;

  assign len_clamped = (req_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : req_len;

  assign bc_start  = cmd_q.start;
  assign bc_stop   = cmd_q.stop;
  assign bc_read   = cmd_q.read;
  assign bc_write  = cmd_q.write;
  assign bc_ack_in = cmd_q.ack_in;
  assign bc_din    = cmd_q.din;

  // Decode which byte-controller command belongs to the current state.
  always_comb begin
    // NOTE: defaults first so every path assigns every bit and no latch forms.
    cmd_want = '0;
    is_cmd   = 1'b1;
    unique case (state)
      ADDR_W: begin
        cmd_want.start = 1'b1;
        cmd_want.write = 1'b1;
        cmd_want.din   = {dev_q, 1'b0};
      end
      REG: begin
        cmd_want.write = 1'b1;
        cmd_want.din   = reg_q;
      end
      WDATA: begin
        cmd_want.write = 1'b1;
        cmd_want.din   = wbyte;
      end
      RSTART: begin
        cmd_want.start = 1'b1;
        cmd_want.write = 1'b1;
        cmd_want.din   = {dev_q, 1'b1};
      end
      RDATA: begin
        cmd_want.read   = 1'b1;
        cmd_want.ack_in = (cnt == LW'(1));  // master-NACK the final byte
      end
      STOP: begin
        cmd_want.stop = 1'b1;
      end
      default: is_cmd = 1'b0;
    endcase
  end

  // Sequencer FSM with registered outputs and command handshake.
  always_ff @(posedge hclk) begin
    if (hrst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state     <= IDLE;
      cmd_q     <= '0;
      cmd_live  <= 1'b0;
      req_ready <= 1'b1;
      tx_ready  <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      done      <= 1'b0;
      status    <= ST_OK;
      busy      <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      rd_q      <= 1'b0;
      cnt       <= '0;
      wbyte     <= '0;
    end else begin
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      done     <= 1'b0;

      if (is_cmd) begin
        if (bc_al) begin
          // Lost the bus: no STOP, report straight away.
          cmd_q    <= '0;
          cmd_live <= 1'b0;
          if (status == ST_OK) status <= ST_AL;
          state    <= FIN;
        end else if (!cmd_live) begin
          cmd_q    <= cmd_want;
          cmd_live <= 1'b1;
        end else if (bc_cmd_ack) begin
          cmd_q    <= '0;
          cmd_live <= 1'b0;
          unique case (state)
            ADDR_W: begin
              if (bc_ack_out) begin
                status <= ST_NACK;
                state  <= STOP;
              end else begin
                state <= REG;
              end
            end
            REG: begin
              if (bc_ack_out) begin
                status <= ST_NACK;
                state  <= STOP;
              end else if (cnt == '0) begin
                state <= STOP;
              end else if (rd_q) begin
                state <= RSTART;
              end else begin
                state <= TX_FETCH;
              end
            end
            WDATA: begin
              cnt <= cnt - LW'(1);
              if (bc_ack_out) begin
                status <= ST_NACK;
                state  <= STOP;
              end else if (cnt == LW'(1)) begin
                state <= STOP;
              end else begin
                state <= TX_FETCH;
              end
            end
            RSTART: begin
              if (bc_ack_out) begin
                status <= ST_NACK;
                state  <= STOP;
              end else begin
                state <= RDATA;
              end
            end
            RDATA: begin
              rx_valid <= 1'b1;
              rx_data  <= bc_dout;
              cnt      <= cnt - LW'(1);
              if (cnt == LW'(1)) state <= STOP;
            end
            STOP:    state <= FIN;
            default: state <= FIN;
          endcase
        end
      end else begin
        unique case (state)
          IDLE: begin
            req_ready <= 1'b1;
            if (req_valid && req_ready) begin
              dev_q     <= req_dev;
              reg_q     <= req_reg;
              rd_q      <= req_rd;
              cnt       <= len_clamped;
              status    <= ST_OK;
              req_ready <= 1'b0;
              busy      <= 1'b1;
              state     <= ADDR_W;
            end
          end
          TX_FETCH: begin
            if (tx_valid) begin
              tx_ready <= 1'b1;
              wbyte    <= tx_data;
              state    <= WDATA;
            end
          end
          FIN: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Testbench for i2c_xfer_seq: a byte-controller model checks every command
// against a queue of expected commands and answers with queued responses;
// received bytes are checked against a queue of expected rx bytes.
module tb_i2c_xfer_seq;

  localparam int LW = 5;

  logic          hclk = 1'b0;
  logic          hrst;
  logic          req_valid;
  logic          req_ready;
  logic [6:0]    req_dev;
  logic [7:0]    req_reg;
  logic          req_rd;
  logic [LW-1:0] req_len;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          done;
  logic [1:0]    status;
  logic          busy;
  logic          bc_start, bc_stop, bc_read, bc_write, bc_ack_in;
  logic [7:0]    bc_din;
  logic          bc_cmd_ack, bc_ack_out, bc_al;
  logic [7:0]    bc_dout;

  i2c_xfer_seq #(.MAX_LEN(16)) dut (
    .hclk(hclk), .hrst(hrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_dev(req_dev),
    .req_reg(req_reg), .req_rd(req_rd), .req_len(req_len),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .done(done), .status(status), .busy(busy),
    .bc_start(bc_start), .bc_stop(bc_stop), .bc_read(bc_read),
    .bc_write(bc_write), .bc_ack_in(bc_ack_in), .bc_din(bc_din),
    .bc_cmd_ack(bc_cmd_ack), .bc_ack_out(bc_ack_out), .bc_dout(bc_dout),
    .bc_al(bc_al)
  );

  always #5 hclk = ~hclk;

  typedef struct packed {
    logic       nack;
    logic       al;
    logic [7:0] dout;
  } resp_t;

  logic [12:0] exp_cmd[$];
  resp_t       resp_q[$];
  logic [7:0]  exp_rx[$];
  logic [7:0]  txq[$];
  int          tx_idx, tx_cnt;
  logic        tx_en;
  int          n_checks, n_fail;
  int          cyc, al_cyc, done_cyc;

  always @(posedge hclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] mk(input logic s, p, r, w, a, input logic [7:0] d);
    return {s, p, r, w, a, d};
  endfunction

  function automatic logic [12:0] cur_cmd();
    return {bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din};
  endfunction

  function automatic logic [27:0] all_outs();
    return {req_ready, tx_ready, rx_valid, rx_data, done, status, busy,
            bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din};
  endfunction

  task automatic push_cmd(input logic [12:0] c, input logic nack, input logic al,
                          input logic [7:0] dout);
    exp_cmd.push_back(c);
    resp_q.push_back('{nack: nack, al: al, dout: dout});
  endtask

  // Byte-controller model: check command, answer after two cycles.
  initial begin
    logic [12:0] obs, e;
    resp_t       r;
    bc_cmd_ack = 1'b0; bc_ack_out = 1'b0; bc_al = 1'b0; bc_dout = '0;
    forever begin
      @(negedge hclk);
      obs = cur_cmd();
      if (!hrst && obs[12:9] != 4'b0) begin
        if (exp_cmd.size() == 0) begin
          check("unexp_cmd", {19'b0, obs}, 32'h0);
          e = obs;
          r = '0;
        end else begin
          e = exp_cmd.pop_front();
          r = resp_q.pop_front();
          check("cmd", {19'b0, obs}, {19'b0, e});
        end
        repeat (2) @(negedge hclk);
        check("cmd_held", {19'b0, cur_cmd()}, {19'b0, e});
        bc_cmd_ack = 1'b1;
        bc_ack_out = r.nack;
        bc_al      = r.al;
        bc_dout    = r.dout;
        if (r.al) al_cyc = cyc;
        @(negedge hclk);
        bc_cmd_ack = 1'b0;
        bc_ack_out = 1'b0;
        bc_al      = 1'b0;
        check("cmd_gap", {19'b0, cur_cmd()}, 32'h0);
      end
    end
  end

  // Write-data source: advance one byte per tx_ready pulse.
  initial begin
    tx_valid = 1'b0; tx_data = '0;
    forever begin
      @(negedge hclk);
      if (tx_ready) begin
        tx_cnt++;
        tx_idx++;
      end
      tx_valid = tx_en && (tx_idx < txq.size());
      tx_data  = tx_valid ? txq[tx_idx] : 8'h00;
    end
  end

  // Receive monitor.
  initial begin
    forever begin
      @(negedge hclk);
      if (rx_valid) begin
        if (exp_rx.size() == 0) check("unexp_rx", 32'h1, 32'h0);
        else check("rx_data", {24'b0, rx_data}, {24'b0, exp_rx.pop_front()});
      end
    end
  end

  task automatic xfer(input logic [6:0] dev, input logic [7:0] rg, input logic rd,
                      input logic [LW-1:0] len, input logic [1:0] exp_st, input int exp_tx);
    int t;
    tx_idx = 0;
    tx_cnt = 0;
    t = 0;
    while (!req_ready && t < 100) begin @(negedge hclk); t++; end
    if (!req_ready) check("req_ready_timeout", 32'h0, 32'h1);
    req_dev = dev; req_reg = rg; req_rd = rd; req_len = len;
    req_valid = 1'b1;
    @(negedge hclk);
    req_valid = 1'b0;
    check("busy_after_accept", {31'b0, busy}, 32'h1);
    t = 0;
    while (!done && t < 3000) begin @(negedge hclk); t++; end
    if (!done) begin
      check("done_timeout", 32'h0, 32'h1);
    end else begin
      done_cyc = cyc;
      check("status", {30'b0, status}, {30'b0, exp_st});
      check("ready_low_at_done", {31'b0, req_ready}, 32'h0);
      @(negedge hclk);
      check("done_pulse", {31'b0, done}, 32'h0);
      check("ready_after_done", {31'b0, req_ready}, 32'h1);
      check("busy_after_done", {31'b0, busy}, 32'h0);
    end
    check("cmds_left", exp_cmd.size(), 32'h0);
    check("rx_left", exp_rx.size(), 32'h0);
    check("tx_count", tx_cnt, exp_tx);
  endtask

  initial begin
    int t;
    n_checks = 0; n_fail = 0; cyc = 0; al_cyc = 0; done_cyc = 0;
    tx_idx = 0; tx_cnt = 0; tx_en = 1'b1;
    hrst = 1'b1; req_valid = 1'b0; req_dev = '0; req_reg = '0; req_rd = 1'b0; req_len = '0;
    repeat (3) @(negedge hclk);
    check("reset_outs", {4'b0, all_outs()}, 32'h0800_0000);
    hrst = 1'b0;
    @(negedge hclk);

    // Write two bytes.
    txq = '{8'hA5, 8'h3C};
    push_cmd(mk(1, 0, 0, 1, 0, 8'hA0), 0, 0, 8'h00);
    push_cmd(mk(0, 0, 0, 1, 0, 8'h10), 0, 0, 8'h00);
    push_cmd(mk(0, 0, 0, 1, 0, 8'hA5), 0, 0, 8'h00);
    push_cmd(mk(0, 0, 0, 1, 0, 8'h3C), 0, 0, 8'h00);
    push_cmd(mk(0, 1, 0, 0, 0, 8'h00), 0, 0, 8'h00);
    xfer(7'h50, 8'h10, 1'b0, 5'd2, 2'b00, 2);

    // Read three bytes, last one master-NACKed.
    txq = '{};
    push_cmd(mk(1, 0, 0, 1, 0, 8'hA0), 0, 0, 8'h00);
    push_cmd(mk(0, 0, 0, 1, 0, 8'h20), 0, 0, 8'h00);
    push_cmd(mk(1, 0, 0, 1, 0, 8'hA1), 0, 0, 8'h00);
    push_cmd(mk(0, 0, 1, 0, 0, 8'h00), 0, 0, 8'h11);
    push_cmd(mk(0, 0, 1, 0, 0, 8'h00), 0, 0, 8'h22);
    push_cmd(mk(0, 0, 1, 0, 1, 8'h00), 0, 0, 8'h33);
    push_cmd(mk(0, 1, 0, 0, 0, 8'h00), 0, 0, 8'h00);
    exp_rx = '{8'h11, 8'h22, 8'h33};
    xfer(7'h50, 8'h20, 1'b1, 5'd3, 2'b00, 0);

    // Address NACK: straight to STOP, nothing consumed.
    txq = '{8'h01, 8'h02};
    push_cmd(mk(1, 0, 0, 1, 0, 8'hA0), 1, 0, 8'h00);
    push_cmd(mk(0, 1, 0, 0, 0, 8'h00), 0, 0, 8'h00);
    xfer(7'h50, 8'h10, 1'b0, 5'd2, 2'b01, 0);

    // NACK on first data byte of a two-byte write.
    txq = '{8'h77, 8'h88};
    push_cmd(mk(1, 0, 0, 1, 0, 8'h6A), 0, 0, 8'h00);
    push_cmd(mk(0, 0, 0, 1, 0, 8'h11), 0, 0, 8'h00);
    push_cmd(mk(0, 0, 0, 1, 0, 8'h77), 1, 0, 8'h00);
    push_cmd(mk(0, 1, 0, 0, 0, 8'h00), 0, 0, 8'h00);
    xfer(7'h35, 8'h11, 1'b0, 5'd2, 2'b01, 1);

    // Arbitration lost during REG, coincident with cmd_ack: no STOP.
    txq = '{8'h55};
    push_cmd(mk(1, 0, 0, 1, 0, 8'hA0), 0, 0, 8'h00);
    push_cmd(mk(0, 0, 0, 1, 0, 8'h10), 0, 1, 8'h00);
    xfer(7'h50, 8'h10, 1'b0, 5'd1, 2'b10, 0);
    check("al_latency", {31'b0, (done_cyc - al_cyc) <= 2}, 32'h1);

    // tx starvation, then reset mid-transfer.
    txq = '{};
    tx_en = 1'b0; tx_idx = 0; tx_cnt = 0;
    push_cmd(mk(1, 0, 0, 1, 0, 8'hA0), 0, 0, 8'h00);
    push_cmd(mk(0, 0, 0, 1, 0, 8'h10), 0, 0, 8'h00);
    req_dev = 7'h50; req_reg = 8'h10; req_rd = 1'b0; req_len = 5'd1;
    req_valid = 1'b1;
    @(negedge hclk);
    req_valid = 1'b0;
    t = 0;
    while (exp_cmd.size() != 0 && t < 200) begin @(negedge hclk); t++; end
    check("starve_cmds_done", exp_cmd.size(), 32'h0);
    repeat (50) @(negedge hclk);
    check("starve_busy", {31'b0, busy}, 32'h1);
    check("starve_bus_idle", {19'b0, cur_cmd()}, 32'h0);
    check("starve_no_tx", tx_cnt, 32'h0);
    hrst = 1'b1;
    @(negedge hclk);
    hrst = 1'b0;
    check("midreset_outs", {4'b0, all_outs()}, 32'h0800_0000);
    @(negedge hclk);
    check("midreset_ready", {31'b0, req_ready}, 32'h1);
    check("midreset_busy", {31'b0, busy}, 32'h0);
    tx_en = 1'b1;

    // Probe: len=0 write and read give START+addr, reg, STOP.
    push_cmd(mk(1, 0, 0, 1, 0, 8'hA0), 0, 0, 8'h00);
    push_cmd(mk(0, 0, 0, 1, 0, 8'h42), 0, 0, 8'h00);
    push_cmd(mk(0, 1, 0, 0, 0, 8'h00), 0, 0, 8'h00);
    xfer(7'h50, 8'h42, 1'b0, 5'd0, 2'b00, 0);
    push_cmd(mk(1, 0, 0, 1, 0, 8'hFE), 0, 0, 8'h00);
    push_cmd(mk(0, 0, 0, 1, 0, 8'h43), 0, 0, 8'h00);
    push_cmd(mk(0, 1, 0, 0, 0, 8'h00), 0, 0, 8'h00);
    xfer(7'h7F, 8'h43, 1'b1, 5'd0, 2'b00, 0);

    // Clamp: req_len=31 moves exactly 16 bytes.
    txq = '{};
    for (int i = 0; i < 20; i++) txq.push_back(8'(8'hC0 + i));
    push_cmd(mk(1, 0, 0, 1, 0, 8'hA0), 0, 0, 8'h00);
    push_cmd(mk(0, 0, 0, 1, 0, 8'h00), 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) push_cmd(mk(0, 0, 0, 1, 0, 8'(8'hC0 + i)), 0, 0, 8'h00);
    push_cmd(mk(0, 1, 0, 0, 0, 8'h00), 0, 0, 8'h00);
    xfer(7'h50, 8'h00, 1'b0, 5'd31, 2'b00, 16);

    repeat (5) @(negedge hclk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
